// File: rtl/gray_pkg.sv
// Shared helpers for the Gray up/down counter: binary/Gray conversion and bound values.
// Functions work on a fixed-width word; callers cast to and from their own width.
package gray_pkg;

  localparam int unsigned MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic word_t max_bin(input int unsigned n);
    word_t ones;
    ones = '1;
    return ones >> (MAX_W - n);
  endfunction

endpackage

// File: rtl/gray_step.sv
// Combinational next-count for one enable step, with wrap/saturate handling at the bounds.
module gray_step
  import gray_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter bit          WRAP = 1'b1
) (
  input  logic [N-1:0] bin,
  input  logic         up,
  input  logic         en,
  output logic [N-1:0] next_bin_c,
  output logic         wrap_c,
  output logic         sat_c
);

  localparam logic [N-1:0] MAX_V = N'(max_bin(N));
  localparam logic [N-1:0] MIN_V = '0;

  logic at_bound_c;

  assign at_bound_c = up ? (bin == MAX_V) : (bin == MIN_V);

  always_comb begin
    next_bin_c = bin;
    wrap_c     = 1'b0;
    sat_c      = 1'b0;
    if (en) begin
      if (!at_bound_c) begin
        next_bin_c = up ? (bin + N'(1)) : (bin - N'(1));
      end else if (WRAP) begin
        next_bin_c = up ? MIN_V : MAX_V;
        wrap_c     = 1'b1;
      end else begin
        sat_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_updown_ctr.sv
// Parametrised up/down Gray counter with clear/load, wrap or saturate, and binary shadow.
// Gray and binary outputs are both direct flops updated from one next-state value.
module gray_updown_ctr
  import gray_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned RST_VAL = 0,
  parameter bit          WRAP    = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         wrap_p,
  output logic         sat_p
);

  localparam logic [N-1:0] RST_BIN  = N'(RST_VAL);
  localparam logic [N-1:0] RST_GRAY = N'(bin2gray(word_t'(RST_VAL)));

  logic [N-1:0] step_bin_c;
  logic         step_wrap_c;
  logic         step_sat_c;
  logic [N-1:0] nxt_bin_c;
  logic [N-1:0] nxt_gray_c;
  logic         nxt_wrap_c;
  logic         nxt_sat_c;

  gray_step #(
    .N    (N),
    .WRAP (WRAP)
  ) u_step (
    .bin        (bin_out),
    .up         (up),
    .en         (en),
    .next_bin_c (step_bin_c),
    .wrap_c     (step_wrap_c),
    .sat_c      (step_sat_c)
  );

  // Sync priority mux: clr > load > en; otherwise hold with pulses low.
  always_comb begin
    nxt_bin_c  = bin_out;
    nxt_gray_c = gray_out;
    nxt_wrap_c = 1'b0;
    nxt_sat_c  = 1'b0;
    if (clr) begin
      nxt_bin_c  = '0;
      nxt_gray_c = '0;
    end else if (load) begin
      nxt_bin_c  = load_val;
      nxt_gray_c = N'(bin2gray(word_t'(load_val)));
    end else if (en) begin
      nxt_bin_c  = step_bin_c;
      nxt_gray_c = N'(bin2gray(word_t'(step_bin_c)));
      nxt_wrap_c = step_wrap_c;
      nxt_sat_c  = step_sat_c;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_out  <= RST_BIN;
      gray_out <= RST_GRAY;
      wrap_p   <= 1'b0;
      sat_p    <= 1'b0;
    end else begin
      bin_out  <= nxt_bin_c;
      gray_out <= nxt_gray_c;
      wrap_p   <= nxt_wrap_c;
      sat_p    <= nxt_sat_c;
    end
  end

endmodule
